// File: rtl/legv8_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// legv8_ctrl_seq_if
//
// Purpose: bundles the command handshake and the datapath control/status
// signals of the LEGv8 control sequencer.
//
// Handshake: a command transfers on a rising clock edge where both
// cmd_valid and cmd_ready are high. The sequencer raises cmd_ready only
// while idle. cmd_valid and the cmd_* fields are looked at only on that
// edge; between transfers the fields may change freely.
//
// Modports:
//   master : command source / datapath side (drives cmd_*, stat, f)
//   slave  : the sequencer (drives cmd_ready and the control word)
//
// Signals:
//   cmd_valid, cmd_ready          command handshake
//   cmd_op/rd/rn/rm/imm           command fields
//   stat {V,C,N,Z}, f             datapath status and ALU result
//   DA, SA, SB, FS, k, addr       control word selects, constant, RAM address
//   W_reg, W_ram, c_out, B_sel    write enables, carry-in, ALU B source
//   B_en, ram_en, alu_en, D_en    bus drivers / RAM enable
//   done, err, stat_q             completion, illegal-op, captured status
// ---------------------------------------------------------------------------
interface legv8_ctrl_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rn;
    logic [4:0]  cmd_rm;
    logic [63:0] cmd_imm;

    logic [3:0]  stat;
    logic [63:0] f;

    logic [4:0]  DA;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  FS;
    logic [63:0] k;
    logic [7:0]  addr;
    logic        W_reg;
    logic        W_ram;
    logic        c_out;
    logic        B_sel;
    logic        B_en;
    logic        ram_en;
    logic        alu_en;
    logic        D_en;
    logic        done;
    logic        err;
    logic [3:0]  stat_q;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, stat, f,
        input  cmd_ready, DA, SA, SB, FS, k, addr, W_reg, W_ram, c_out,
               B_sel, B_en, ram_en, alu_en, D_en, done, err, stat_q
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, stat, f,
        output cmd_ready, DA, SA, SB, FS, k, addr, W_reg, W_ram, c_out,
               B_sel, B_en, ram_en, alu_en, D_en, done, err, stat_q
    );
endinterface

// File: rtl/legv8_ctrl_seq.sv
// ---------------------------------------------------------------------------
// legv8_ctrl_seq
//
// Purpose: multi-cycle control sequencer for the LEGv8 datapath (register
// file, ALU and RAM sharing one data bus). One command is accepted at a
// time and expanded into one (ALU ops) or two (LDUR/STUR) control words.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous reset, active-high; forces the idle control word
//              combinationally while high
//   bus        legv8_ctrl_seq_if.slave (handshake, control word, status)
//   dbg_state  current FSM state: 0 IDLE, 1 EXEC, 2 ADDR, 3 MEM
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 ADDI, 5 SUBI, 6 LDUR, 7 STUR,
//          8 CBZ, 9 MOVZ, 10-15 illegal (err pulse, nothing executed).
// ---------------------------------------------------------------------------
module legv8_ctrl_seq (
    input  logic             clk,
    input  logic             rst,
    legv8_ctrl_seq_if.slave  bus,
    output logic [1:0]       dbg_state
);

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] XZR    = 5'd31;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORR  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_SUBI = 4'd5;
    localparam logic [3:0] OP_LDUR = 4'd6;
    localparam logic [3:0] OP_STUR = 4'd7;
    localparam logic [3:0] OP_CBZ  = 4'd8;
    localparam logic [3:0] OP_MOVZ = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ADDR = 2'd2,
        S_MEM  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Latched command fields
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  rn_q;
    logic [4:0]  rm_q;
    logic [63:0] imm_q;

    // Registered outputs
    logic [7:0]  addr_q;
    logic        done_q;
    logic        err_q;
    logic [3:0]  stat_q;

    // Control word (combinational)
    logic [4:0]  da, sa, sb, fs;
    logic [63:0] k_w;
    logic        w_reg, w_ram, c_in, b_sel, b_en, ram_en, alu_en, d_en;

    logic        cmd_ready;
    logic        accept;
    logic        in_legal;
    logic        in_mem;
    logic        rd_ok;

    // Only the low byte of the ALU result forms a RAM address.
    logic        unused_f_hi;
    assign unused_f_hi = ^bus.f[63:8];

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = bus.cmd_valid && cmd_ready;
    assign in_legal  = (bus.cmd_op <= OP_MOVZ);
    assign in_mem    = (bus.cmd_op == OP_LDUR) || (bus.cmd_op == OP_STUR);
    // Writes to the zero register are suppressed at the source.
    assign rd_ok     = (rd_q != XZR);

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= XZR;
            rn_q    <= XZR;
            rm_q    <= XZR;
            imm_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            // done lands in the IDLE cycle after the last control word
            done_q  <= (state_q == S_EXEC) || (state_q == S_MEM);
            err_q   <= accept && !in_legal;
            if (accept) begin
                op_q  <= bus.cmd_op;
                rd_q  <= bus.cmd_rd;
                rn_q  <= bus.cmd_rn;
                rm_q  <= bus.cmd_rm;
                imm_q <= bus.cmd_imm;
            end
            if (state_q == S_ADDR) begin
                addr_q <= bus.f[7:0];
            end
            // EXEC and ADDR are the only cycles where the ALU computes
            if ((state_q == S_EXEC) || (state_q == S_ADDR)) begin
                stat_q <= bus.stat;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and control word
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        da      = XZR;
        sa      = XZR;
        sb      = XZR;
        fs      = FS_ADD;
        k_w     = '0;
        w_reg   = 1'b0;
        w_ram   = 1'b0;
        c_in    = 1'b0;
        b_sel   = 1'b0;
        b_en    = 1'b0;
        ram_en  = 1'b0;
        alu_en  = 1'b0;
        d_en    = 1'b0;

        // Under reset the idle word is held even mid-command so no write
        // can slip out in the reset cycle.
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (in_mem) begin
                            state_d = S_ADDR;
                        end else if (in_legal) begin
                            state_d = S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    state_d = S_IDLE;
                    alu_en  = 1'b1;
                    if (op_q != OP_CBZ) begin
                        w_reg = rd_ok;
                        da    = rd_q;
                    end
                    case (op_q)
                        OP_ADD: begin
                            sa = rn_q;
                            sb = rm_q;
                        end
                        OP_SUB: begin
                            sa   = rn_q;
                            sb   = rm_q;
                            fs   = FS_SUB;
                            c_in = 1'b1;
                        end
                        OP_AND: begin
                            sa = rn_q;
                            sb = rm_q;
                            fs = FS_AND;
                        end
                        OP_ORR: begin
                            sa = rn_q;
                            sb = rm_q;
                            fs = FS_ORR;
                        end
                        OP_ADDI: begin
                            sa    = rn_q;
                            b_sel = 1'b1;
                            k_w   = imm_q;
                        end
                        OP_SUBI: begin
                            sa    = rn_q;
                            b_sel = 1'b1;
                            k_w   = imm_q;
                            fs    = FS_SUB;
                            c_in  = 1'b1;
                        end
                        OP_CBZ: begin
                            // rn + XZR: only the flags matter
                            sa = rn_q;
                        end
                        OP_MOVZ: begin
                            b_sel = 1'b1;
                            k_w   = imm_q;
                        end
                        default: begin
                        end
                    endcase
                end

                S_ADDR: begin
                    state_d = S_MEM;
                    sa      = rn_q;
                    b_sel   = 1'b1;
                    k_w     = imm_q;
                    alu_en  = 1'b1;
                end

                S_MEM: begin
                    state_d = S_IDLE;
                    ram_en  = 1'b1;
                    if (op_q == OP_LDUR) begin
                        d_en  = 1'b1;
                        w_reg = rd_ok;
                        da    = rd_q;
                    end else begin
                        sb    = rm_q;
                        b_en  = 1'b1;
                        w_ram = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.DA        = da;
    assign bus.SA        = sa;
    assign bus.SB        = sb;
    assign bus.FS        = fs;
    assign bus.k         = k_w;
    assign bus.addr      = addr_q;
    assign bus.W_reg     = w_reg;
    assign bus.W_ram     = w_ram;
    assign bus.c_out     = c_in;
    assign bus.B_sel     = b_sel;
    assign bus.B_en      = b_en;
    assign bus.ram_en    = ram_en;
    assign bus.alu_en    = alu_en;
    assign bus.D_en      = d_en;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.stat_q    = stat_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_legv8_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_legv8_ctrl_seq
//
// Drives legv8_ctrl_seq through directed and random commands. A small
// datapath (register file, ALU, RAM) reacts to the control word so real
// values flow; a separate architectural model predicts register/RAM
// contents, status flags, timing and the key control-word fields.
// ---------------------------------------------------------------------------
module tb_legv8_ctrl_seq;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] XZR    = 5'd31;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    legv8_ctrl_seq_if bus ();
    logic [1:0] dbg_state;

    legv8_ctrl_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- datapath environment ----------------
    logic [63:0] regs [32]  = '{default: '0};
    logic [63:0] ram  [256] = '{default: '0};

    logic [63:0] env_a, env_bv, env_bin, env_bx, env_r, env_data;
    logic [64:0] env_sum;
    logic        env_c, env_v;

    always_comb begin
        env_a   = (bus.SA == XZR) ? 64'd0 : regs[bus.SA];
        env_bv  = (bus.SB == XZR) ? 64'd0 : regs[bus.SB];
        env_bin = bus.B_sel ? bus.k : env_bv;
        env_bx  = (bus.FS == FS_SUB) ? ~env_bin : env_bin;
        env_sum = {1'b0, env_a} + {1'b0, env_bx} + {64'd0, bus.c_out};
        env_r   = env_sum[63:0];
        env_c   = env_sum[64];
        env_v   = (env_a[63] == env_bx[63]) && (env_r[63] != env_a[63]);
        if (bus.FS == FS_AND) begin
            env_r = env_a & env_bin;
            env_c = 1'b0;
            env_v = 1'b0;
        end else if (bus.FS == FS_ORR) begin
            env_r = env_a | env_bin;
            env_c = 1'b0;
            env_v = 1'b0;
        end
        bus.f    = env_r;
        bus.stat = {env_v, env_c, env_r[63], env_r == 64'd0};
        env_data = 64'd0;
        if (bus.alu_en)     env_data = env_r;
        else if (bus.B_en)  env_data = env_bv;
        else if (bus.D_en)  env_data = ram[bus.addr];
    end

    always @(posedge clk) begin
        if (bus.W_reg && bus.DA != XZR) regs[bus.DA] <= env_data;
        if (bus.W_ram) ram[bus.addr] <= env_data;
    end

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // architectural reference state
    logic [63:0] exp_regs [32]  = '{default: '0};
    logic [63:0] exp_ram  [256] = '{default: '0};
    logic [3:0]  exp_stat_q     = 4'd0;
    logic        mon_en         = 1'b0;

    function automatic logic [63:0] rv(input logic [4:0] i);
        return (i == XZR) ? 64'd0 : exp_regs[i];
    endfunction

    // add/subtract result with {V,C,N,Z}; C on subtract means "no borrow"
    task automatic model_arith(input logic [63:0] a, input logic [63:0] b,
                               input logic sub, output logic [63:0] r,
                               output logic [3:0] fl);
        logic c, v;
        if (sub) begin
            r = a - b;
            c = (a >= b);
            v = (a[63] != b[63]) && (r[63] != a[63]);
        end else begin
            r = a + b;
            c = (r < a);
            v = (a[63] == b[63]) && (r[63] != a[63]);
        end
        fl = {v, c, r[63], r == 64'd0};
    endtask

    // bus exclusivity and XZR protection, every cycle outside reset
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("bus_excl", ($countones({bus.alu_en, bus.B_en, bus.D_en}) <= 1), 1);
            if (bus.W_reg) check("xzr_write", bus.DA == XZR, 0);
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rn, input logic [4:0] rm,
                           input logic [63:0] imm);
        logic [63:0] a, b, r;
        logic [3:0]  fl;
        logic        legal, mem, wr, bsel_e, cout_e;
        logic [4:0]  fs_e;
        logic [7:0]  ad;
        int          lat, waited;

        a = rv(rn); b = rv(rm);
        legal = (op <= 4'd9);
        mem = (op == 4'd6) || (op == 4'd7);
        wr = 1'b0; r = 64'd0; fl = exp_stat_q; ad = 8'd0;
        fs_e = FS_ADD; cout_e = 1'b0; bsel_e = 1'b0;
        case (op)
            4'd0: begin model_arith(a, b, 1'b0, r, fl); wr = 1'b1; end
            4'd1: begin model_arith(a, b, 1'b1, r, fl); wr = 1'b1; fs_e = FS_SUB; cout_e = 1'b1; end
            4'd2: begin r = a & b; fl = {2'b00, r[63], r == 64'd0}; wr = 1'b1; fs_e = FS_AND; end
            4'd3: begin r = a | b; fl = {2'b00, r[63], r == 64'd0}; wr = 1'b1; fs_e = FS_ORR; end
            4'd4: begin model_arith(a, imm, 1'b0, r, fl); wr = 1'b1; bsel_e = 1'b1; end
            4'd5: begin model_arith(a, imm, 1'b1, r, fl); wr = 1'b1; bsel_e = 1'b1; fs_e = FS_SUB; cout_e = 1'b1; end
            4'd6: begin model_arith(a, imm, 1'b0, r, fl); ad = r[7:0]; wr = 1'b1; end
            4'd7: begin model_arith(a, imm, 1'b0, r, fl); ad = r[7:0]; end
            4'd8: model_arith(a, 64'd0, 1'b0, r, fl);
            4'd9: begin model_arith(64'd0, imm, 1'b0, r, fl); wr = 1'b1; bsel_e = 1'b1; end
            default: ;
        endcase
        wr  = wr && (rd != XZR);
        lat = !legal ? 1 : (mem ? 3 : 2);

        waited = 0;
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_cmd", bus.cmd_ready, 1);

        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rn = rn; bus.cmd_rm = rm; bus.cmd_imm = imm;
        @(posedge clk);
        @(negedge clk);
        // fields must have been latched; change them while busy
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 4'($urandom); bus.cmd_rd = 5'($urandom);
        bus.cmd_rn = 5'($urandom); bus.cmd_rm = 5'($urandom);
        bus.cmd_imm = {$urandom, $urandom};

        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            if (!legal) begin
                check("illegal_err", bus.err, 1);
                check("illegal_done", bus.done, 0);
                check("illegal_wreg", bus.W_reg, 0);
                check("illegal_wram", bus.W_ram, 0);
                check("illegal_ready", bus.cmd_ready, 1);
                check("illegal_stat_q", bus.stat_q, exp_stat_q);
            end else if (c == lat) begin
                check("done", bus.done, 1);
                check("ready_at_done", bus.cmd_ready, 1);
                check("stat_q", bus.stat_q, fl);
            end else if (!mem) begin
                check("exec_alu_en", bus.alu_en, 1);
                check("exec_wreg", bus.W_reg, wr);
                if (wr) check("exec_da", bus.DA, rd);
                check("exec_fs", bus.FS, fs_e);
                check("exec_c_out", bus.c_out, cout_e);
                check("exec_b_sel", bus.B_sel, bsel_e);
                if (bsel_e) check("exec_k", bus.k, imm);
                check("exec_wram", bus.W_ram, 0);
                check("exec_done", bus.done, 0);
                check("exec_err", bus.err, 0);
            end else if (c == 1) begin
                check("addr_alu_en", bus.alu_en, 1);
                check("addr_sa", bus.SA, rn);
                check("addr_b_sel", bus.B_sel, 1);
                check("addr_k", bus.k, imm);
                check("addr_fs", bus.FS, FS_ADD);
                check("addr_wreg", bus.W_reg, 0);
                check("addr_wram", bus.W_ram, 0);
                check("addr_done", bus.done, 0);
            end else begin
                check("mem_addr", bus.addr, ad);
                check("mem_ram_en", bus.ram_en, 1);
                if (op == 4'd7) begin
                    check("stur_wram", bus.W_ram, 1);
                    check("stur_b_en", bus.B_en, 1);
                    check("stur_sb", bus.SB, rm);
                    check("stur_wreg", bus.W_reg, 0);
                end else begin
                    check("ldur_d_en", bus.D_en, 1);
                    check("ldur_wreg", bus.W_reg, wr);
                    if (wr) check("ldur_da", bus.DA, rd);
                    check("ldur_wram", bus.W_ram, 0);
                end
            end
        end

        if (legal) begin
            exp_stat_q = fl;
            if (op == 4'd7) exp_ram[ad] = b;
            else if (op == 4'd6) begin
                if (wr) exp_regs[rd] = exp_ram[ad];
            end else if (wr) exp_regs[rd] = r;
        end
    endtask

    // STUR abandoned by a reset asserted during its MEM cycle
    task automatic reset_mid_stur(input logic [4:0] rn, input logic [4:0] rm,
                                  input logic [63:0] imm);
        check("rst_test_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 4'd7; bus.cmd_rd = 5'd0; bus.cmd_rn = rn; bus.cmd_rm = rm; bus.cmd_imm = imm;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mem_wram", bus.W_ram, 0);
        check("rst_mem_b_en", bus.B_en, 0);
        check("rst_mem_ram_en", bus.ram_en, 0);
        check("rst_mem_ready", bus.cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_stat_q = 4'd0;
        #1;
        check("rst_state_idle", dbg_state, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_done", bus.done, 0);
        check("rst_stat_q", bus.stat_q, 0);
        @(negedge clk);
        check("rst_no_done", bus.done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  op;
        logic [63:0] imm;

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 4'd0; bus.cmd_rd = 5'd0; bus.cmd_rn = 5'd0; bus.cmd_rm = 5'd0;
        bus.cmd_imm = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_wreg", bus.W_reg, 0);
        check("rst_fs", bus.FS, FS_ADD);
        check("rst_da", bus.DA, XZR);
        check("rst_k", bus.k, 0);
        rst = 1'b0;
        #1;
        check("post_rst_addr", bus.addr, 0);
        check("post_rst_done", bus.done, 0);
        check("post_rst_err", bus.err, 0);
        check("post_rst_stat_q", bus.stat_q, 0);
        check("post_rst_state", dbg_state, 0);
        check("post_rst_ready", bus.cmd_ready, 1);
        mon_en = 1'b1;

        // directed
        run_cmd(4'd9, 5'd1, 5'd0, 5'd0, 64'd5);          // MOVZ r1 = 5
        run_cmd(4'd0, 5'd2, 5'd1, 5'd1, 64'd0);          // ADD  r2 = 10
        run_cmd(4'd1, 5'd3, 5'd2, 5'd2, 64'd0);          // SUB  r3 = 0, Z
        run_cmd(4'd7, 5'd0, 5'd1, 5'd2, 64'd3);          // STUR [8] = 10
        run_cmd(4'd6, 5'd4, XZR, 5'd0, 64'd8);           // LDUR r4 = [8]
        run_cmd(4'hF, 5'd7, 5'd1, 5'd1, 64'd1);          // illegal
        run_cmd(4'd4, XZR, 5'd1, 5'd0, 64'd7);           // ADDI to XZR
        run_cmd(4'd8, 5'd9, 5'd3, 5'd0, 64'd0);          // CBZ r3
        run_cmd(4'd4, 5'd5, XZR, 5'd0, 64'd256);         // ADDI r5 = 256
        run_cmd(4'd6, 5'd6, 5'd5, 5'd0, 64'd0);          // LDUR addr wraps to 0
        reset_mid_stur(5'd1, 5'd2, 64'd20);
        run_cmd(4'd9, 5'd10, 5'd0, 5'd0, 64'h1234);      // normal after reset

        // random
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) != 0) op = 4'($urandom_range(0, 9));
            else op = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 1) != 0) imm = {$urandom, $urandom};
            else imm = 64'($urandom_range(0, 300));
            run_cmd(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), imm);
        end

        @(negedge clk);
        mon_en = 1'b0;
        for (int i = 0; i < 31; i++) check($sformatf("reg%0d", i), regs[i], exp_regs[i]);
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== exp_ram[i] || i < 16) check($sformatf("ram%0d", i), ram[i], exp_ram[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/legv8_ctrl_seq.md
Name: legv8_ctrl_seq

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath (register file, ALU, RAM on shared data bus).
- Accepts one command at a time over a valid/ready handshake.
- Expands each command into one or two datapath control words (DA/SA/SB/FS/k/addr plus enables).
- Reports completion, the captured ALU status and illegal-opcode errors.

Parameters:
- FS_ADD, 5'b01000, ALU function code for add.
- FS_SUB, 5'b01001, ALU function code for subtract (used with c_out=1).
- FS_AND, 5'b00000, ALU function code for bitwise AND.
- FS_ORR, 5'b00100, ALU function code for bitwise OR.
- XZR, 5'd31, zero-register index; also the idle value of DA/SA/SB.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (IDLE)
- cmd_op  in  4  opcode, see Behaviour
- cmd_rd  in  5  destination register
- cmd_rn  in  5  first source / base register
- cmd_rm  in  5  second source / store-data register
- cmd_imm  in  64  immediate / offset
- stat  in  4  datapath status {V,C,N,Z}
- f  in  64  ALU result (low 8 bits used as RAM address)
- DA, SA, SB  out  5 each  register write/read-A/read-B select
- FS  out  5  ALU function select
- k  out  64  constant to ALU B input
- addr  out  8  RAM address (registered)
- W_reg, W_ram  out  1 each  register-file / RAM write enables
- c_out  out  1  ALU carry-in
- B_sel  out  1  ALU B source: 1 = k, 0 = register B
- B_en  out  1  register-B read port drives data bus
- ram_en  out  1  RAM chip enable
- alu_en  out  1  ALU drives data bus
- D_en  out  1  RAM read data drives data bus
- done  out  1  one-cycle pulse, command complete
- err  out  1  one-cycle pulse, illegal opcode
- stat_q  out  4  stat captured at the last ALU cycle of the most recent command

Behaviour:
- States: IDLE, EXEC, ADDR, MEM.
- Command capture:
  - cmd_ready = 1 only in IDLE and not rst.
  - Accept = cmd_valid && cmd_ready at a rising edge; the op, rd, rn, rm and imm fields are latched on accept.
  - Inputs are ignored while busy.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 ORR: register-register; SA=rn, SB=rm, B_sel=0.
  - 4 ADDI, 5 SUBI: SA=rn, B_sel=1, k=imm.
  - 6 LDUR, 7 STUR: base rn, offset imm.
  - 8 CBZ: test only; SA=rn, SB=XZR, FS_ADD, no write.
  - 9 MOVZ: SA=XZR, k=imm, FS_ADD, write rd.
  - 10-15: illegal.
- Transitions:
  - IDLE→EXEC on accept of ops 0-5, 8, 9.
  - IDLE→ADDR on accept of ops 6-7.
  - Illegal op: stays IDLE; err=1 the next cycle; no write enable is ever asserted; done is not asserted.
  - EXEC→IDLE; ADDR→MEM; MEM→IDLE.
- EXEC control word:
  - alu_en=1; FS per op; c_out=1 for SUB/SUBI, else 0.
  - W_reg=1 with DA=rd, except CBZ (W_reg=0).
  - stat_q <= stat at end of cycle.
- ADDR control word:
  - SA=rn, B_sel=1, k=imm, FS_ADD, alu_en=1, W_reg=0, W_ram=0.
  - addr <= f[7:0] at end of cycle; addr wraps modulo 256.
  - stat_q <= stat.
- MEM control word:
  - LDUR: ram_en=1, D_en=1, W_reg=1, DA=rd.
  - STUR: SB=rm, B_en=1, ram_en=1, W_ram=1.
- done timing:
  - done=1 in the IDLE cycle following EXEC or MEM.
  - cmd_ready is simultaneously 1, so back-to-back commands have exactly one bubble.
  - Latency from accept edge to done: 2 cycles (single-cycle ops), 3 cycles (LDUR/STUR).
- Idle control word:
  - All enables and writes 0, c_out=0, B_sel=0, FS=FS_ADD, DA=SA=SB=XZR, k=0.
  - addr holds its value.
- Bus exclusivity: at most one of alu_en, B_en, D_en is high in any cycle.
- XZR destination: when the destination register is 31, W_reg is forced to 0.
- Reset:
  - While rst=1, the idle control word is output combinationally (no write in the reset cycle, even mid-command).
  - After the edge: state=IDLE, addr=0, done=0, err=0, stat_q=0.
  - A command in flight is abandoned with no done.

Test Plan:
- Reset, then MOVZ rd=1 imm=5 → one EXEC cycle with W_reg=1, DA=1, k=5; r1=5; done 2 cycles after accept.
- ADD rd=2 rn=1 rm=1, then SUB rd=3 rn=2 rm=2 → r2=10, r3=0, c_out=1 during SUB; stat_q Z=1 after SUB.
- STUR rn=1 rm=2 imm=3, then LDUR rd=4 rn=XZR imm=8 → STUR: addr=8 in MEM, W_ram=1 with B_en=1; LDUR: r4=10, D_en=1, W_reg=1; done 3 cycles after each accept.
- cmd_op=4'hF → err pulse next cycle; W_reg, W_ram and done stay 0; cmd_ready remains 1.
- ADDI rd=31 rn=1 imm=7 → W_reg=0 throughout. CBZ rn=3 → stat_q[0]=1 and no register change. ADDI rn=XZR imm=256, then LDUR → addr=0 (wrap).
- STUR accepted, rst=1 during MEM cycle → W_ram=0 in that cycle; state IDLE, addr=0, no done; a command issued afterwards executes normally.
